// File: rtl/csr_access_pkg.sv
// Shared types and constants for the CSR access initiator.
// Zicsr funct3 codes, CSR unit op encodings and FSM states.
package csr_access_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NONE  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // addr[11:10] of the read-only CSR space
    localparam logic [1:0] RO_SPACE = 2'b11;

endpackage

// File: rtl/csr_req_decode.sv
// Combinational Zicsr request decode: operand, op, write/read
// suppression and illegal-access detection.
module csr_req_decode
    import csr_access_pkg::*;
#(
    parameter bit RO_CHECK          = 1'b1,
    parameter bit ILLEGAL_ON_BAD_F3 = 1'b1
) (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_hi_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  rs1_idx_i,
    input  logic [4:0]  rd_idx_i,
    output logic [31:0] operand_o,
    output csr_op_e     op_o,
    output logic        do_write_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    csr_op_e base;
    logic    bad_f3;
    logic    writes;
    logic    ro_hit;

    // Decode funct3; set/clear with x0/zimm=0 never write
    always_comb begin
        base   = OP_NONE;
        bad_f3 = 1'b0;
        unique case (funct3_i[1:0])
            2'b01:   base = OP_WRITE;
            2'b10:   base = OP_SET;
            2'b11:   base = OP_CLEAR;
            default: bad_f3 = 1'b1;
        endcase
        operand_o = funct3_i[2] ? {27'b0, rs1_idx_i} : rs1_data_i;
        writes = !bad_f3 && ((base == OP_WRITE) || (rs1_idx_i != 5'd0));
        ro_hit = RO_CHECK && (addr_hi_i == RO_SPACE) && writes;
        illegal_o  = (bad_f3 && ILLEGAL_ON_BAD_F3) || ro_hit;
        do_write_o = writes && !illegal_o;
        op_o       = do_write_o ? base : OP_NONE;
        rd_we_o    = !bad_f3 && !illegal_o && (rd_idx_i != 5'd0);
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Pipeline-side CSR access initiator: one Zicsr instruction per
// handshake, single-cycle CSR access, old value returned for rd.
module csr_access_ctrl
    import csr_access_pkg::*;
#(
    parameter bit RO_CHECK          = 1'b1,
    parameter bit ILLEGAL_ON_BAD_F3 = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_funct3_i,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_rs1_data_i,
    input  logic [4:0]  req_rs1_idx_i,
    input  logic [4:0]  req_rd_idx_i,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    output logic [1:0]  csr_op_o,
    output logic        csr_we_o,
    input  logic [31:0] csr_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rd_data_o,
    output logic [4:0]  rsp_rd_idx_o,
    output logic        rsp_rd_we_o,
    output logic        rsp_illegal_o
);

    state_e      state_q, state_d;
    logic [11:0] addr_q;
    logic [31:0] data_q;
    csr_op_e     op_q;
    logic        we_q;
    logic [4:0]  rd_idx_q;
    logic        rd_we_q;
    logic        ill_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_idx_q;
    logic        rsp_we_q;
    logic        rsp_ill_q;

    logic [31:0] dec_operand;
    csr_op_e     dec_op;
    logic        dec_we;
    logic        dec_rd_we;
    logic        dec_ill;
    logic        accept;

    csr_req_decode #(
        .RO_CHECK          (RO_CHECK),
        .ILLEGAL_ON_BAD_F3 (ILLEGAL_ON_BAD_F3)
    ) u_decode (
        .funct3_i   (req_funct3_i),
        .addr_hi_i  (req_addr_i[11:10]),
        .rs1_data_i (req_rs1_data_i),
        .rs1_idx_i  (req_rs1_idx_i),
        .rd_idx_i   (req_rd_idx_i),
        .operand_o  (dec_operand),
        .op_o       (dec_op),
        .do_write_o (dec_we),
        .rd_we_o    (dec_rd_we),
        .illegal_o  (dec_ill)
    );

    // Next state plus per-state handshake and CSR strobes
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        csr_we_o    = 1'b0;
        csr_op_o    = OP_NONE;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = rst_ni;
                if (req_valid_i && rst_ni) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                csr_we_o = we_q;
                csr_op_o = op_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = req_valid_i && req_ready_o;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Capture the decoded request on acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            data_q   <= '0;
            op_q     <= OP_NONE;
            we_q     <= 1'b0;
            rd_idx_q <= '0;
            rd_we_q  <= 1'b0;
            ill_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr_i;
            data_q   <= dec_operand;
            op_q     <= dec_op;
            we_q     <= dec_we;
            rd_idx_q <= req_rd_idx_i;
            rd_we_q  <= dec_rd_we;
            ill_q    <= dec_ill;
        end
    end

    // Latch the pre-write CSR value and response fields after ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_q <= '0;
            rsp_idx_q  <= '0;
            rsp_we_q   <= 1'b0;
            rsp_ill_q  <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            rsp_data_q <= ill_q ? 32'd0 : csr_data_i;
            rsp_idx_q  <= rd_idx_q;
            rsp_we_q   <= rd_we_q;
            rsp_ill_q  <= ill_q;
        end
    end

    assign csr_addr_o    = addr_q;
    assign csr_data_o    = data_q;
    assign rsp_rd_data_o = rsp_data_q;
    assign rsp_rd_idx_o  = rsp_idx_q;
    assign rsp_rd_we_o   = rsp_we_q;
    assign rsp_illegal_o = rsp_ill_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed table,
// reset-abort sequence and randomized traffic against a CSR model.
module tb_csr_access_ctrl;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  idx;
        logic [4:0]  rd;
        int          dly;
        logic        we;
        logic [1:0]  op;
        logic [31:0] rdd;
        logic        rd_we;
        logic        ill;
        logic [31:0] newv;
        logic        we2;
    } row_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i = '0;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_rs1_data_i = '0;
    logic [4:0]  req_rs1_idx_i = '0;
    logic [4:0]  req_rd_idx_i = '0;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_data_o;
    logic [1:0]  csr_op_o;
    logic        csr_we_o;
    logic [31:0] csr_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rd_data_o;
    logic [4:0]  rsp_rd_idx_o;
    logic        rsp_rd_we_o;
    logic        rsp_illegal_o;

    // second instance with both checks disabled
    logic        req_ready2;
    logic [11:0] csr_addr2;
    logic [31:0] csr_data2;
    logic [1:0]  csr_op2;
    logic        csr_we2;
    logic [31:0] csr_rdata2 = 32'h0;
    logic        rsp_valid2;
    logic [31:0] rsp_rd_data2;
    logic [4:0]  rsp_rd_idx2;
    logic        rsp_rd_we2;
    logic        rsp_illegal2;

    logic [31:0] csr_mem [0:4095];
    bit          mem_clr = 1'b1;

    int passed = 0;
    int total  = 0;

    csr_access_ctrl #(.RO_CHECK(1'b1), .ILLEGAL_ON_BAD_F3(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
        .req_rs1_data_i(req_rs1_data_i), .req_rs1_idx_i(req_rs1_idx_i),
        .req_rd_idx_i(req_rd_idx_i),
        .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
        .csr_op_o(csr_op_o), .csr_we_o(csr_we_o), .csr_data_i(csr_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rd_data_o(rsp_rd_data_o), .rsp_rd_idx_o(rsp_rd_idx_o),
        .rsp_rd_we_o(rsp_rd_we_o), .rsp_illegal_o(rsp_illegal_o)
    );

    csr_access_ctrl #(.RO_CHECK(1'b0), .ILLEGAL_ON_BAD_F3(1'b0)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready2),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
        .req_rs1_data_i(req_rs1_data_i), .req_rs1_idx_i(req_rs1_idx_i),
        .req_rd_idx_i(req_rd_idx_i),
        .csr_addr_o(csr_addr2), .csr_data_o(csr_data2),
        .csr_op_o(csr_op2), .csr_we_o(csr_we2), .csr_data_i(csr_rdata2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready_i),
        .rsp_rd_data_o(rsp_rd_data2), .rsp_rd_idx_o(rsp_rd_idx2),
        .rsp_rd_we_o(rsp_rd_we2), .rsp_illegal_o(rsp_illegal2)
    );

    always #5 clk_i = ~clk_i;

    // CSR unit stand-in: combinational read, write on the clock edge
    always_comb csr_data_i = csr_mem[csr_addr_o];

    always @(posedge clk_i) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
            csr_mem[12'h301] <= 32'h40000100;
            csr_mem[12'hC00] <= 32'h00001234;
        end else if (csr_we_o) begin
            case (csr_op_o)
                2'b00:   csr_mem[csr_addr_o] <= csr_data_o;
                2'b01:   csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] | csr_data_o;
                2'b10:   csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] & ~csr_data_o;
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: Zicsr rules applied to one instruction and the old CSR value
    function automatic row_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [31:0] rs1, input logic [4:0] idx,
                                   input logic [4:0] rd, input logic [31:0] old,
                                   input bit ro, input bit badill);
        row_t r;
        logic [31:0] opnd;
        bit bad, writes;
        r.f3 = f3; r.addr = addr; r.rs1 = rs1; r.idx = idx; r.rd = rd;
        r.dly = 0; r.we2 = 1'b0;
        opnd = f3[2] ? 32'(idx) : rs1;
        bad = (f3[1:0] == 2'd0);
        writes = !bad && (f3[1:0] == 2'd1 || idx != 0);
        r.ill = (bad && badill) || (ro && addr[11:10] == 2'b11 && writes);
        r.we = writes && !r.ill;
        if (!r.we) r.op = 2'b11;
        else if (f3[1:0] == 2'd1) r.op = 2'b00;
        else if (f3[1:0] == 2'd2) r.op = 2'b01;
        else r.op = 2'b10;
        r.rd_we = !bad && !r.ill && rd != 0;
        r.rdd = r.ill ? 32'h0 : old;
        if (!r.we) r.newv = old;
        else if (f3[1:0] == 2'd1) r.newv = opnd;
        else if (f3[1:0] == 2'd2) r.newv = old | opnd;
        else r.newv = old & ~opnd;
        return r;
    endfunction

    task automatic run_txn(input row_t r);
        row_t e2;
        logic [31:0] opnd;
        logic [31:0] held;
        opnd = r.f3[2] ? 32'(r.idx) : r.rs1;
        e2 = model(r.f3, r.addr, r.rs1, r.idx, r.rd, csr_mem[r.addr], 1'b0, 1'b0);
        chk("idle_req_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_funct3_i = r.f3; req_addr_i = r.addr;
        req_rs1_data_i = r.rs1; req_rs1_idx_i = r.idx; req_rd_idx_i = r.rd;
        @(posedge clk_i); @(negedge clk_i);
        req_valid_i = 1'b0;
        req_funct3_i = 3'($urandom); req_addr_i = 12'($urandom);
        req_rs1_data_i = $urandom; req_rs1_idx_i = 5'($urandom);
        req_rd_idx_i = 5'($urandom);
        chk("acc_we", 32'(csr_we_o), 32'(r.we));
        chk("acc_addr", 32'(csr_addr_o), 32'(r.addr));
        chk("acc_data", csr_data_o, opnd);
        if (!r.ill) chk("acc_op", 32'(csr_op_o), 32'(r.op));
        chk("acc_req_ready", 32'(req_ready_o), 32'd0);
        chk("acc_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("acc_we2", 32'(csr_we2), 32'(r.we2));
        chk("acc_op2", 32'(csr_op2), 32'(e2.op));
        chk("acc_addr2", 32'(csr_addr2), 32'(r.addr));
        chk("acc_data2", csr_data2, opnd);
        @(posedge clk_i); @(negedge clk_i);
        chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rsp_rd_data", rsp_rd_data_o, r.rdd);
        chk("rsp_rd_idx", 32'(rsp_rd_idx_o), 32'(r.rd));
        chk("rsp_rd_we", 32'(rsp_rd_we_o), 32'(r.rd_we));
        chk("rsp_illegal", 32'(rsp_illegal_o), 32'(r.ill));
        chk("csr_new_value", csr_mem[r.addr], r.newv);
        chk("rsp_csr_we", 32'(csr_we_o), 32'd0);
        chk("rsp_csr_op", 32'(csr_op_o), 32'h3);
        chk("rsp_addr_hold", 32'(csr_addr_o), 32'(r.addr));
        chk("rsp_valid2", 32'(rsp_valid2), 32'd1);
        chk("rsp_illegal2", 32'(rsp_illegal2), 32'(e2.ill));
        chk("rsp_rd_we2", 32'(rsp_rd_we2), 32'(e2.rd_we));
        chk("rsp_rd_data2", rsp_rd_data2, 32'h0);
        chk("rsp_rd_idx2", 32'(rsp_rd_idx2), 32'(r.rd));
        chk("rsp_req_ready2", 32'(req_ready2), 32'd0);
        held = rsp_rd_data_o;
        for (int k = 0; k < r.dly; k++) begin
            rsp_ready_i = 1'b0;
            req_valid_i = 1'($urandom);
            @(posedge clk_i); @(negedge clk_i);
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rd_data", rsp_rd_data_o, held);
            chk("bp_rd_we", 32'(rsp_rd_we_o), 32'(r.rd_we));
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            chk("bp_csr_we", 32'(csr_we_o), 32'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("done_req_ready", 32'(req_ready_o), 32'd1);
    endtask

    row_t tbl [12];
    row_t r;
    logic [31:0] old340;
    logic [11:0] addrs [6];

    initial begin
        //        f3      addr    rs1  idx rd dly we op   rdd           rdwe ill newv         we2
        tbl[0]  = '{3'b001, 12'h300, 32'h8,  5'd1,  5'd5,  0, 1, 2'b00, 32'h0,        1, 0, 32'h8,        1};
        tbl[1]  = '{3'b010, 12'h300, 32'h0,  5'd0,  5'd6,  0, 0, 2'b11, 32'h8,        1, 0, 32'h8,        0};
        tbl[2]  = '{3'b010, 12'h301, 32'h0,  5'd0,  5'd7,  0, 0, 2'b11, 32'h40000100, 1, 0, 32'h40000100, 0};
        tbl[3]  = '{3'b101, 12'hC00, 32'h0,  5'd3,  5'd4,  0, 0, 2'b11, 32'h0,        0, 1, 32'h1234,     1};
        tbl[4]  = '{3'b111, 12'h300, 32'h0,  5'd8,  5'd0,  0, 1, 2'b10, 32'h8,        0, 0, 32'h0,        1};
        tbl[5]  = '{3'b000, 12'h300, 32'h0,  5'd5,  5'd3,  0, 0, 2'b11, 32'h0,        0, 1, 32'h0,        0};
        tbl[6]  = '{3'b010, 12'h300, 32'hF0, 5'd2,  5'd1,  5, 1, 2'b01, 32'h0,        1, 0, 32'hF0,       1};
        tbl[7]  = '{3'b011, 12'h300, 32'h30, 5'd9,  5'd2,  1, 1, 2'b10, 32'hF0,       1, 0, 32'hC0,       1};
        tbl[8]  = '{3'b110, 12'hC01, 32'h0,  5'd0,  5'd1,  0, 0, 2'b11, 32'h0,        1, 0, 32'h0,        0};
        tbl[9]  = '{3'b001, 12'hC01, 32'h5,  5'd0,  5'd1,  0, 0, 2'b11, 32'h0,        0, 1, 32'h0,        1};
        tbl[10] = '{3'b101, 12'h340, 32'h0,  5'd31, 5'd31, 2, 1, 2'b00, 32'h0,        1, 0, 32'h1F,       1};
        tbl[11] = '{3'b111, 12'hC00, 32'h0,  5'd0,  5'd2,  0, 0, 2'b11, 32'h1234,     1, 0, 32'h1234,     0};
        addrs[0] = 12'h300; addrs[1] = 12'h301; addrs[2] = 12'h340;
        addrs[3] = 12'hC00; addrs[4] = 12'hC01; addrs[5] = 12'hF11;

        @(negedge clk_i); @(negedge clk_i);
        mem_clr = 1'b0;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_csr_we", 32'(csr_we_o), 32'd0);
        chk("rst_csr_op", 32'(csr_op_o), 32'h3);
        chk("rst_csr_addr", 32'(csr_addr_o), 32'h0);
        chk("rst_csr_data", csr_data_o, 32'h0);
        chk("rst_rd_data", rsp_rd_data_o, 32'h0);
        chk("rst_rd_idx", 32'(rsp_rd_idx_o), 32'h0);
        chk("rst_rd_we", 32'(rsp_rd_we_o), 32'h0);
        chk("rst_illegal", 32'(rsp_illegal_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // reset during ACCESS with a pending write
        old340 = csr_mem[12'h340];
        req_valid_i = 1'b1; req_funct3_i = 3'b001; req_addr_i = 12'h340;
        req_rs1_data_i = 32'hAA; req_rs1_idx_i = 5'd1; req_rd_idx_i = 5'd1;
        @(posedge clk_i); @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("abort_we_before", 32'(csr_we_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort_we_drop", 32'(csr_we_o), 32'd0);
        chk("abort_op", 32'(csr_op_o), 32'h3);
        chk("abort_ready_low", 32'(req_ready_o), 32'd0);
        @(posedge clk_i); @(negedge clk_i);
        chk("abort_no_write", csr_mem[12'h340], old340);
        chk("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("abort_ready_back", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); @(negedge clk_i);
        chk("abort_still_no_rsp", 32'(rsp_valid_o), 32'd0);
        r = model(3'b010, 12'h340, 32'h0, 5'd0, 5'd9, csr_mem[12'h340], 1'b1, 1'b1);
        r.we2 = 1'b0;
        run_txn(r);

        // randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [11:0] a;
            logic [31:0] d;
            logic [4:0]  ix, rd;
            f3 = 3'($urandom);
            a  = addrs[$urandom_range(0, 5)];
            d  = $urandom;
            ix = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r = model(f3, a, d, ix, rd, csr_mem[a], 1'b1, 1'b1);
            r.we2 = model(f3, a, d, ix, rd, csr_mem[a], 1'b0, 1'b0).we;
            r.dly = $urandom_range(0, 3);
            run_txn(r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
